// File: rtl/rng_arbiter_if.sv
// ----------------------------------------------------------------------------
// rng_arbiter_if
// Purpose : Groups the requester handshake, reseed control and Random32
//           generator hookup of rng_arbiter into one bundle.
// Signals :
//   req          [NREQ] level request per requester
//   gnt          [NREQ] one-hot, single-cycle grant
//   data         [32]   random word delivered with gnt
//   reseed_req   [1]    single-cycle reseed pulse
//   reseed_value [32]   seed sampled with reseed_req
//   busy         [1]    arbiter is loading or warming the generator
//   rng_rstn     [1]    active-low reset to Random32
//   rng_seed     [32]   seed to Random32
//   rng_number   [32]   current Random32 output word
// Modports:
//   slave  : the arbiter side
//   master : the environment side (requesters plus the generator itself)
// ----------------------------------------------------------------------------
interface rng_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] gnt;
    logic [31:0]     data;
    logic            reseed_req;
    logic [31:0]     reseed_value;
    logic            busy;
    logic            rng_rstn;
    logic [31:0]     rng_seed;
    logic [31:0]     rng_number;

    modport slave (
        input  req,
        input  reseed_req,
        input  reseed_value,
        input  rng_number,
        output gnt,
        output data,
        output busy,
        output rng_rstn,
        output rng_seed
    );

    modport master (
        output req,
        output reseed_req,
        output reseed_value,
        output rng_number,
        input  gnt,
        input  data,
        input  busy,
        input  rng_rstn,
        input  rng_seed
    );
endinterface

// File: rtl/rng_arbiter.sv
// ----------------------------------------------------------------------------
// rng_arbiter
// Purpose : Owns the single Random32 generator and shares it between NREQ
//           requesters with round-robin arbitration. Sequences the generator
//           reset/seed load after rst and on every accepted reseed request,
//           discards a few warm-up words, and leaves an idle gap after every
//           grant so the generator has stepped before the next word is handed
//           out (no two grants ever see the same word).
// Ports   :
//   clk  in  system clock
//   rst  in  asynchronous reset, active-high
//   bus  rng_arbiter_if.slave (req, gnt, data, reseed_req, reseed_value,
//        busy, rng_rstn, rng_seed, rng_number)
// Optional feature:
//   RNG_ZERO_SEED_GUARD_EN - when defined, a requested seed of 32'h0 (which
//   would lock the LFSR at zero) is replaced by DEFAULT_SEED. When undefined
//   the requested seed is loaded verbatim.
// ----------------------------------------------------------------------------
module rng_arbiter #(
    parameter int          NREQ         = 4,
    parameter logic [31:0] DEFAULT_SEED = 32'h4789_FA12,
    parameter int          RST_CYC      = 2,
    parameter int          WARM_CYC     = 4,
    parameter int          REFRESH_CYC  = 1
) (
    input  logic          clk,
    input  logic          rst,
    rng_arbiter_if.slave  bus
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNT_W = 16;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_WARM  = 2'd1,
        ST_SERVE = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [PTR_W-1:0]  r_ptr;
    logic [NREQ-1:0]   r_gnt;
    logic [31:0]       r_data;
    logic              r_busy;
    logic              r_rng_rstn;
    logic [31:0]       r_rng_seed;

    logic              w_any;
    logic [PTR_W-1:0]  w_winner;
    logic [PTR_W-1:0]  w_idx;

    // Seed actually presented to the generator for a requested value.
    function automatic logic [31:0] f_seed_sel(input logic [31:0] v);
`ifdef RNG_ZERO_SEED_GUARD_EN
        if (v == 32'h0000_0000) begin
            f_seed_sel = DEFAULT_SEED;
        end else begin
            f_seed_sel = v;
        end
`else
        f_seed_sel = v;
`endif
    endfunction

    // Round-robin search: first requester strictly after r_ptr, wrapping.
    always_comb begin
        w_any    = 1'b0;
        w_winner = r_ptr;
        w_idx    = r_ptr;
        for (int k = 1; k <= NREQ; k++) begin
            w_idx = PTR_W'((int'(r_ptr) + k) % NREQ);
            if (!w_any && bus.req[w_idx]) begin
                w_any    = 1'b1;
                w_winner = w_idx;
            end else begin
                w_any    = w_any;
            end
        end
    end

    // Main sequencer: load/warm/serve/hold with all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_LOAD;
            r_cnt      <= {CNT_W{1'b0}};
            r_ptr      <= PTR_W'(NREQ - 1);
            r_gnt      <= {NREQ{1'b0}};
            r_data     <= 32'h0000_0000;
            r_busy     <= 1'b1;
            r_rng_rstn <= 1'b0;
            r_rng_seed <= DEFAULT_SEED;
        end else begin
            // grant is a single-cycle pulse unless the SERVE branch sets it
            r_gnt <= {NREQ{1'b0}};
            case (r_state)
                ST_LOAD: begin
                    if (r_cnt == CNT_W'(RST_CYC - 1)) begin
                        r_state    <= ST_WARM;
                        r_cnt      <= {CNT_W{1'b0}};
                        r_rng_rstn <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_WARM: begin
                    if (r_cnt == CNT_W'(WARM_CYC - 1)) begin
                        r_state <= ST_SERVE;
                        r_cnt   <= {CNT_W{1'b0}};
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_SERVE: begin
                    // reseed has priority; pending requests simply wait
                    if (bus.reseed_req) begin
                        r_state    <= ST_LOAD;
                        r_cnt      <= {CNT_W{1'b0}};
                        r_busy     <= 1'b1;
                        r_rng_rstn <= 1'b0;
                        r_rng_seed <= f_seed_sel(bus.reseed_value);
                    end else if (w_any) begin
                        r_state <= ST_HOLD;
                        r_cnt   <= {CNT_W{1'b0}};
                        r_gnt   <= {{(NREQ-1){1'b0}}, 1'b1} << w_winner;
                        r_data  <= bus.rng_number;
                        r_ptr   <= w_winner;
                    end else begin
                        r_state <= ST_SERVE;
                    end
                end
                ST_HOLD: begin
                    if (r_cnt == CNT_W'(REFRESH_CYC - 1)) begin
                        r_state <= ST_SERVE;
                        r_cnt   <= {CNT_W{1'b0}};
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state    <= ST_LOAD;
                    r_cnt      <= {CNT_W{1'b0}};
                    r_busy     <= 1'b1;
                    r_rng_rstn <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gnt      = r_gnt;
    assign bus.data     = r_data;
    assign bus.busy     = r_busy;
    assign bus.rng_rstn = r_rng_rstn;
    assign bus.rng_seed = r_rng_seed;

endmodule
